// File: rtl/uart_receiver_if.sv
// -----------------------------------------------------------------------------
// uart_receiver_if
// Byte-side interface of the UART receive stage.
//   data_out        received byte, stable while data_out_valid is high
//   data_out_valid  a byte is waiting in the holding register
//   data_out_ready  consumer accepts the byte when valid&ready at a rising edge
//   framing_error   one-cycle pulse: stop bit sampled low, byte discarded
//   overrun         one-cycle pulse: completed byte dropped, holding register full
// master = the receiver (produces bytes), slave = the consumer (MMIO/FIFO).
// -----------------------------------------------------------------------------
interface uart_receiver_if;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       framing_error;
    logic       overrun;

    modport master (
        output data_out,
        output data_out_valid,
        output framing_error,
        output overrun,
        input  data_out_ready
    );

    modport slave (
        input  data_out,
        input  data_out_valid,
        input  framing_error,
        input  overrun,
        output data_out_ready
    );
endinterface

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// 8N1 UART receive stage. The asynchronous RX line is resynchronised by two
// flops, a falling edge starts a frame, each bit is sampled near its centre and
// the completed byte is parked in a holding register behind a valid/ready pair.
// Ports:
//   clk        system clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   serial_in  asynchronous RX line, idle high
//   bus        byte-side interface (master modport): data_out, data_out_valid,
//              data_out_ready, framing_error, overrun
// -----------------------------------------------------------------------------
module uart_receiver #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              serial_in,
    uart_receiver_if.master   bus
);

    localparam int CLOCKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_POINT   = CLOCKS_PER_BIT / 2;
    localparam int CNT_W          = $clog2(CLOCKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(SAMPLE_POINT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Line resynchroniser and edge-detect history
    logic             sync1_r;
    logic             rx_r;
    logic             rx_prev_r;

    // Frame tracking
    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;

    // Registered outputs
    logic [7:0]       data_out_r;
    logic             data_valid_r;
    logic             framing_error_r;
    logic             overrun_r;

    // Per-cycle strobes decoded from the FSM
    logic             fall_edge_s;
    logic             at_mid_s;
    logic             at_last_s;
    logic             start_ok_s;
    logic             data_sample_s;
    logic             frame_done_s;
    logic             frame_err_s;

    assign fall_edge_s = rx_prev_r & ~rx_r;
    assign at_mid_s    = (cnt_r == CNT_MID);
    assign at_last_s   = (cnt_r == CNT_LAST);

    // Two-flop synchroniser plus one flop of history for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r   <= 1'b1;
            rx_r      <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            sync1_r   <= serial_in;
            rx_r      <= sync1_r;
            rx_prev_r <= rx_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; a held-low line never re-arms because only a
    // 1->0 transition leaves IDLE
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fall_edge_s) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (at_mid_s) begin
                    // a start bit that is high again at its centre was a glitch
                    state_next_s = rx_r ? ST_IDLE : ST_DATA;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (at_last_s && (bit_idx_r == 3'd7)) begin
                    state_next_s = ST_STOP;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_STOP: begin
                // leaving at mid-stop-bit leaves half a bit to catch the next start edge
                if (at_last_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode: sampling strobes for the datapath
    always_comb begin
        start_ok_s    = 1'b0;
        data_sample_s = 1'b0;
        frame_done_s  = 1'b0;
        frame_err_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                start_ok_s = 1'b0;
            end
            ST_START: begin
                if (at_mid_s && !rx_r) begin
                    start_ok_s = 1'b1;
                end else begin
                    start_ok_s = 1'b0;
                end
            end
            ST_DATA: begin
                if (at_last_s) begin
                    data_sample_s = 1'b1;
                end else begin
                    data_sample_s = 1'b0;
                end
            end
            ST_STOP: begin
                if (at_last_s) begin
                    frame_done_s = rx_r;
                    frame_err_s  = ~rx_r;
                end else begin
                    frame_done_s = 1'b0;
                    frame_err_s  = 1'b0;
                end
            end
            default: begin
                start_ok_s = 1'b0;
            end
        endcase
    end

    // Bit timer: cleared on every state change and on every data sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else if ((state_next_s != state_r) || data_sample_s || (state_r == ST_IDLE)) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Bit index and LSB-first shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
        end else if (start_ok_s) begin
            bit_idx_r <= 3'd0;
        end else if (data_sample_s) begin
            shift_r[bit_idx_r] <= rx_r;
            bit_idx_r          <= bit_idx_r + 3'd1;
        end else begin
            bit_idx_r <= bit_idx_r;
        end
    end

    // Holding register, handshake and error pulses; a completion in the same
    // cycle as a handshake replaces the consumed byte instead of dropping it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_r      <= 8'h00;
            data_valid_r    <= 1'b0;
            framing_error_r <= 1'b0;
            overrun_r       <= 1'b0;
        end else begin
            framing_error_r <= frame_err_s;
            overrun_r       <= 1'b0;
            if (frame_done_s) begin
                if (!data_valid_r || bus.data_out_ready) begin
                    data_out_r   <= shift_r;
                    data_valid_r <= 1'b1;
                end else begin
                    overrun_r <= 1'b1;
                end
            end else if (data_valid_r && bus.data_out_ready) begin
                data_valid_r <= 1'b0;
            end else begin
                data_valid_r <= data_valid_r;
            end
        end
    end

    assign bus.data_out       = data_out_r;
    assign bus.data_out_valid = data_valid_r;
    assign bus.framing_error  = framing_error_r;
    assign bus.overrun        = overrun_r;

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
// Directed bench for uart_receiver at 10 clocks per bit. Single frames come
// from a vector table; back-to-back overrun, glitch rejection and mid-frame
// reset are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

    localparam int CPB = 10;

    logic clk;
    logic rst_n;
    logic serial_in;

    uart_receiver_if bus ();

    uart_receiver #(
        .CLOCK_FREQ (1_000_000),
        .BAUD_RATE  (100_000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .serial_in (serial_in),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Event counters, written only by the monitor
    int valid_cyc = 0;
    int ferr_cnt  = 0;
    int ovr_cnt   = 0;

    always @(negedge clk) begin
        if (bus.data_out_valid === 1'b1) valid_cyc <= valid_cyc + 1;
        if (bus.framing_error === 1'b1)  ferr_cnt  <= ferr_cnt + 1;
        if (bus.overrun === 1'b1)        ovr_cnt   <= ovr_cnt + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_data;
        int         exp_valid;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        serial_in = b;
        idle(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [7:0] v;
        v = d;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(v[i]);
        drive_bit(stop);
        serial_in = 1'b1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data"},  {24'h0, bus.data_out}, 32'h0);
        check({tag, "_valid"}, {31'h0, bus.data_out_valid}, 32'h0);
        check({tag, "_ferr"},  {31'h0, bus.framing_error}, 32'h0);
        check({tag, "_ovr"},   {31'h0, bus.overrun}, 32'h0);
    endtask

    int v0, f0, o0;

    initial begin
        vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_data: 8'hA5, exp_valid: 1, exp_ferr: 0};
        vecs[1] = '{data: 8'h55, stop: 1'b0, exp_data: 8'hA5, exp_valid: 0, exp_ferr: 1};
        vecs[2] = '{data: 8'h01, stop: 1'b1, exp_data: 8'h01, exp_valid: 1, exp_ferr: 0};
        vecs[3] = '{data: 8'h00, stop: 1'b1, exp_data: 8'h00, exp_valid: 1, exp_ferr: 0};
        vecs[4] = '{data: 8'h80, stop: 1'b1, exp_data: 8'h80, exp_valid: 1, exp_ferr: 0};
        vecs[5] = '{data: 8'h7E, stop: 1'b1, exp_data: 8'h7E, exp_valid: 1, exp_ferr: 0};

        // Reset while idle
        rst_n = 1'b0;
        serial_in = 1'b1;
        bus.data_out_ready = 1'b1;
        idle(3);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        idle(30);
        check("post_reset_valid", {31'h0, bus.data_out_valid}, 32'h0);
        check("post_reset_events", valid_cyc + ferr_cnt + ovr_cnt, 32'h0);

        // Table of single frames, consumer always ready
        for (int k = 0; k < 6; k++) begin
            v0 = valid_cyc; f0 = ferr_cnt; o0 = ovr_cnt;
            send_frame(vecs[k].data, vecs[k].stop);
            idle(5);
            check($sformatf("vec%0d_valid_cycles", k), valid_cyc - v0, vecs[k].exp_valid);
            check($sformatf("vec%0d_ferr_pulses", k), ferr_cnt - f0, vecs[k].exp_ferr);
            check($sformatf("vec%0d_ovr_pulses", k), ovr_cnt - o0, 32'h0);
            check($sformatf("vec%0d_data", k), {24'h0, bus.data_out}, {24'h0, vecs[k].exp_data});
            check($sformatf("vec%0d_valid_low", k), {31'h0, bus.data_out_valid}, 32'h0);
        end

        // Back-to-back frames with the consumer stalled
        bus.data_out_ready = 1'b0;
        v0 = valid_cyc; f0 = ferr_cnt; o0 = ovr_cnt;
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        idle(5);
        check("b2b_valid_held", {31'h0, bus.data_out_valid}, 32'h1);
        check("b2b_data", {24'h0, bus.data_out}, 32'h3C);
        check("b2b_ovr_pulses", ovr_cnt - o0, 32'h1);
        check("b2b_ferr_pulses", ferr_cnt - f0, 32'h0);
        bus.data_out_ready = 1'b1;
        idle(1);
        check("b2b_valid_drop", {31'h0, bus.data_out_valid}, 32'h0);
        check("b2b_data_after", {24'h0, bus.data_out}, 32'h3C);

        // Short low glitch on an idle line
        idle(10);
        v0 = valid_cyc; f0 = ferr_cnt; o0 = ovr_cnt;
        serial_in = 1'b0;
        idle(3);
        serial_in = 1'b1;
        idle(20);
        check("glitch_events", (valid_cyc - v0) + (ferr_cnt - f0) + (ovr_cnt - o0), 32'h0);
        send_frame(8'hFF, 1'b1);
        idle(5);
        check("glitch_next_valid", valid_cyc - v0, 32'h1);
        check("glitch_next_data", {24'h0, bus.data_out}, 32'hFF);

        // Reset during data bit 4 of a frame
        idle(10);
        v0 = valid_cyc; f0 = ferr_cnt; o0 = ovr_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        serial_in = 1'b0;
        idle(5);
        rst_n = 1'b0;
        idle(2);
        check_outputs_zero("midframe_reset");
        serial_in = 1'b1;
        rst_n = 1'b1;
        idle(40);
        check("midframe_no_events", (valid_cyc - v0) + (ferr_cnt - f0) + (ovr_cnt - o0), 32'h0);
        send_frame(8'h81, 1'b1);
        idle(5);
        check("after_reset_valid", valid_cyc - v0, 32'h1);
        check("after_reset_data", {24'h0, bus.data_out}, 32'h81);
        check("after_reset_ferr", ferr_cnt - f0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
